if_id_pipe_stage: RTL
=====================

# if_id_pipe_stage

Parametrised fetch/decode pipeline stage with a valid/ready handshake, hold-on-stall, flush-to-bubble and a saturating stall counter. It sits between instruction fetch and decode. It replaces the plain write-enabled IF/ID register: on a stall it holds its value instead of driving unknowns, and on a flush it inserts a NOP bubble. An optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- PC_W, 32, width of the PC field
- INSTR_W, 32, width of the instruction field
- NOP_INSTR, 32'h00000013, bubble instruction encoding (`addi x0,x0,0`)
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock, rising edge
- res  in  1  asynchronous active-low reset
- flush  in  1  kill all held and incoming entries this cycle
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept an entry
- in_pc  in  PC_W  fetched PC
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode accepts the entry
- out_pc  out  PC_W  registered PC
- out_instr  out  INSTR_W  registered instruction, NOP_INSTR when empty
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- Main register M drives out_*.
- Reset (res=0, asynchronous): out_valid=0, out_pc=0, out_instr=NOP_INSTR, stall_cnt=0, skid empty, in_ready=1.
- flush=1 has priority over every other event:
  - next cycle out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid empty;
  - any input firing in the same cycle is discarded;
  - stall_cnt is not affected.
- Without skid, in_ready = out_ready || !out_valid (combinational):
  - in_ready=1 and in_valid=1: M loads in_pc/in_instr, out_valid=1.
  - in_ready=1 and in_valid=0: M becomes a bubble (out_valid=0, out_instr=NOP_INSTR, out_pc=0).
  - in_ready=0: M holds every field unchanged. Stalls never produce X.
- stall_cnt increments when out_valid && !out_ready, evaluated before flush. It saturates at all-ones and clears only on reset.

## Timing
- Latency: one cycle from input fire to out_valid.
- Throughput: one entry per cycle while out_ready=1.
- out_* never change while out_valid=1 and out_ready=0, except on flush.
- Reset deassertion takes effect synchronously at the next clk edge. Reset asserted mid-stall empties the stage immediately.
- Simultaneous input fire and output fire: M replaced by the new entry, no bubble.
- With skid, in_ready is a register output and has no combinational path from out_ready.

## Configuration
- IF_ID_PIPE_STAGE_SKID_EN defined: adds a one-entry skid register S.
  - in_ready = !S.valid, registered.
  - When M is empty or fires: M loads from S if S is valid, otherwise from the input. S is vacated.
  - When M is full, M does not fire and the input fires: the entry is captured in S.
  - Ordering is preserved; no entry is lost or duplicated.
  - flush empties both M and S.
- IF_ID_PIPE_STAGE_SKID_EN undefined: no S, combinational in_ready as described under Operation.
- Latency is one cycle in both builds.

## Test plan
- Reset: assert res=0 mid-traffic -> out_valid=0, out_pc=0, out_instr=32'h00000013, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1; push PC 0x0, 0x4, 0x8 on consecutive cycles -> same values on out_pc one cycle later, no gaps.
- Stall: hold out_ready=0 for 5 cycles with PC 0x10 valid -> out_pc stays 0x10, instruction stable, stall_cnt=5. Without skid, in_ready=0.
- Skid (SKID_EN): out_ready drops while PC 0x20 is held and PC 0x24 is pushed -> 0x24 captured in S, in_ready=0. Releasing out_ready delivers 0x20 then 0x24.
- Flush: assert flush with valid entries in M and S and in_valid=1 -> next cycle out_valid=0, out_instr=NOP, all three entries dropped.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=4'hF and holds.

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage
//   IF/ID pipeline register with valid/ready handshake. Holds its contents
//   on a decode stall, turns into a NOP bubble on flush or when fetch has
//   nothing to offer, and counts stalled cycles in a saturating counter.
//
//   Optional build macro IF_ID_PIPE_STAGE_SKID_EN adds a one-entry skid
//   register so that in_ready is a flop output with no combinational path
//   from out_ready.
//
// Ports
//   clk        in   rising-edge clock
//   res        in   asynchronous active-low reset
//   flush      in   drop held and incoming entries this cycle
//   in_valid   in   fetch presents an entry
//   in_ready   out  stage can accept an entry
//   in_pc      in   fetched PC             [PC_W]
//   in_instr   in   fetched instruction    [INSTR_W]
//   out_valid  out  decode-side entry valid
//   out_ready  in   decode accepts the entry
//   out_pc     out  registered PC          [PC_W]
//   out_instr  out  registered instruction, NOP_INSTR when empty [INSTR_W]
//   stall_cnt  out  saturating count of out_valid && !out_ready cycles [CNT_W]
module if_id_pipe_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Main register M
  logic               m_valid_q, m_valid_d;
  logic [PC_W-1:0]    m_pc_q,    m_pc_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // M may take a new value when empty or when decode consumes it
  logic m_adv;
  logic in_fire;

  assign m_adv = !m_valid_q || out_ready;

  // Stall counting looks at the pre-flush state and is never cleared by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

`ifdef IF_ID_PIPE_STAGE_SKID_EN
  // Skid register S catches the entry accepted while M is stalled
  logic               s_valid_q, s_valid_d;
  logic [PC_W-1:0]    s_pc_q,    s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;

  // in_ready is a pure function of a flop
  assign in_ready = !s_valid_q;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_instr_d = m_instr_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_instr_d = NOP_INSTR;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_instr_d = NOP_INSTR;
    end else if (m_adv) begin
      // S holds the older entry; when S is full in_ready is low, so no
      // input can fire in the same cycle and ordering is preserved.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_pc_d    = s_pc_q;
        m_instr_d = s_instr_q;
        s_valid_d = 1'b0;
        s_pc_d    = '0;
        s_instr_d = NOP_INSTR;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_instr_d = in_instr;
      end else begin
        m_valid_d = 1'b0;
        m_pc_d    = '0;
        m_instr_d = NOP_INSTR;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_pc_d    = in_pc;
      s_instr_d = in_instr;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_instr_q <= NOP_INSTR;
    end else begin
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
    end
  end
`else
  assign in_ready = m_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_instr_d = m_instr_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_instr_d = NOP_INSTR;
    end else if (in_fire) begin
      m_valid_d = 1'b1;
      m_pc_d    = in_pc;
      m_instr_d = in_instr;
    end else if (m_adv) begin
      // Nothing offered: drain to a clean bubble rather than keep stale data
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_instr_d = NOP_INSTR;
    end
  end
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      m_valid_q   <= 1'b0;
      m_pc_q      <= '0;
      m_instr_q   <= NOP_INSTR;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_pc_q      <= m_pc_d;
      m_instr_q   <= m_instr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_pc    = m_pc_q;
  assign out_instr = m_instr_q;
  assign stall_cnt = stall_cnt_q;

endmodule
